seq_muldiv_unit: RTL and testbench

- Multi-cycle, parametrised multiply/divide unit that replaces the single-cycle mul/div paths of the combinational ALU.
- Supports signed and unsigned modes, start/busy/done handshake and divide-by-zero detection.
- Result is a 2*BITS word: {HI, LO}. The control unit issues `start`, stalls on `busy`, then latches `result` into HI/LO when `done` pulses.

---
 rtl/seq_muldiv_unit_pkg.sv | 9 +
 rtl/seq_muldiv_unit_if.sv | 13 +
 rtl/seq_muldiv_unit_datapath.sv | 54 +++++
 rtl/seq_muldiv_unit.sv | 57 +++++
 tb/tb_seq_muldiv_unit.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/seq_muldiv_unit_pkg.sv
// muldiv_pkg: shared op/state encodings and a conditional negate helper for the mul/div unit
package muldiv_pkg;
    typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MULU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_t;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;
    localparam int MAX_W = 512;
    function automatic logic [MAX_W-1:0] cneg(input logic [MAX_W-1:0] v, input logic en);
        return en ? ~v + MAX_W'(1) : v;
    endfunction
endpackage

// File: rtl/seq_muldiv_unit_if.sv
// seq_muldiv_unit_if: start/busy/done request bus between control unit and mul/div unit
interface seq_muldiv_unit_if import muldiv_pkg::*; #(parameter int BITS = 32);
    logic start;
    op_t op;
    logic [BITS-1:0] X;
    logic [BITS-1:0] Y;
    logic busy;
    logic done;
    logic div_by_zero;
    logic [2*BITS-1:0] result;
    modport master (output start, op, X, Y, input busy, done, div_by_zero, result);
    modport slave (input start, op, X, Y, output busy, done, div_by_zero, result);
endinterface

// File: rtl/seq_muldiv_unit_datapath.sv
// muldiv_datapath: magnitude capture, shift-add / restoring-divide step and sign fix-up
module muldiv_datapath import muldiv_pkg::*; #(parameter int BITS = 32) (
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic              step,
    input  logic              fix,
    input  op_t               op,
    input  logic [BITS-1:0]   x,
    input  logic [BITS-1:0]   y,
    output logic [2*BITS-1:0] result
);
    logic is_div, div_in, dz_in, sgn, sxn, syn, sx, sy;
    logic [BITS-1:0] b, xm, ym;
    logic [BITS:0] sum, shifted, diff;
    logic [2*BITS-1:0] acc, mul_nxt, div_nxt, fixed;
    always_comb begin
        div_in  = op == OP_DIV || op == OP_DIVU;
        dz_in   = div_in && y == '0;
        sgn     = op == OP_MUL || op == OP_DIV;
        sxn     = sgn & x[BITS-1];
        syn     = sgn & y[BITS-1];
        xm      = BITS'(cneg(MAX_W'(x), sxn));
        ym      = BITS'(cneg(MAX_W'(y), syn));
        sum     = {1'b0, acc[2*BITS-1:BITS]} + (acc[0] ? {1'b0, b} : '0);
        mul_nxt = {sum, acc[BITS-1:1]};
        shifted = {acc[2*BITS-1:BITS], acc[BITS-1]};
        diff    = shifted - {1'b0, b};
        div_nxt = {diff[BITS] ? shifted[BITS-1:0] : diff[BITS-1:0], acc[BITS-2:0], ~diff[BITS]};
        fixed   = !is_div ? (2*BITS)'(cneg(MAX_W'(acc), sx ^ sy))
                : {BITS'(cneg(MAX_W'(acc[2*BITS-1:BITS]), sx)), BITS'(cneg(MAX_W'(acc[BITS-1:0]), sx ^ sy))};
    end
    // a divide by zero leaves {X, all ones} in acc with signs cleared, so the fix-up passes it through
    always_ff @(posedge clk) begin
        if (clr) begin
            is_div <= 1'b0;
            sx     <= 1'b0;
            sy     <= 1'b0;
            b      <= '0;
            acc    <= '0;
            result <= '0;
        end else if (load) begin
            is_div <= div_in;
            sx     <= sxn & ~dz_in;
            sy     <= syn & ~dz_in;
            b      <= div_in ? ym : xm;
            acc    <= dz_in ? {x, {BITS{1'b1}}} : {{BITS{1'b0}}, div_in ? xm : ym};
        end else if (step) begin
            acc <= is_div ? div_nxt : mul_nxt;
        end else if (fix) begin
            result <= fixed;
        end
    end
endmodule

// File: rtl/seq_muldiv_unit.sv
// seq_muldiv_unit: multi-cycle signed/unsigned multiply/divide with start/busy/done handshake
module seq_muldiv_unit import muldiv_pkg::*; #(parameter int BITS = 32) (
    input logic              clk,
    input logic              clr,
    seq_muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(BITS + 1);
    state_t state, nxt;
    logic [CNT_W-1:0] cnt;
    logic accept, dz_req, dz_op, dz;
    assign accept = state == S_IDLE && bus.start;
    assign dz_req = (bus.op == OP_DIV || bus.op == OP_DIVU) && bus.Y == '0;
    always_ff @(posedge clk) begin
        if (clr) state <= S_IDLE;
        else state <= nxt;
    end
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt   <= '0;
            dz_op <= 1'b0;
            dz    <= 1'b0;
        end else begin
            if (accept) begin
                cnt   <= CNT_W'(BITS);
                dz_op <= dz_req;
                dz    <= 1'b0;
            end else if (state == S_RUN) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (state == S_FIX) dz <= dz_op;
        end
    end
    // divide by zero skips RUN but still passes through FIX to form its result
    always_comb begin
        nxt = state;
        if (accept) nxt = dz_req ? S_FIX : S_RUN;
        else if (state == S_RUN && cnt == CNT_W'(1)) nxt = S_FIX;
        else if (state == S_FIX) nxt = S_DONE;
        else if (state == S_DONE) nxt = S_IDLE;
    end
    always_comb begin
        bus.busy        = state != S_IDLE;
        bus.done        = state == S_DONE;
        bus.div_by_zero = dz;
    end
    muldiv_datapath #(.BITS(BITS)) u_dp (
        .clk    (clk),
        .clr    (clr),
        .load   (accept),
        .step   (state == S_RUN),
        .fix    (state == S_FIX),
        .op     (bus.op),
        .x      (bus.X),
        .y      (bus.Y),
        .result (bus.result)
    );
endmodule

// File: tb/tb_seq_muldiv_unit.sv
// tb_seq_muldiv_unit: directed self-checking bench against an arithmetic reference model
module tb_seq_muldiv_unit;
    import muldiv_pkg::*;
    logic clk = 1'b0;
    logic clr = 1'b1;
    always #5 clk = ~clk;
    seq_muldiv_unit_if #(.BITS(32)) bus();
    seq_muldiv_unit #(.BITS(32)) dut (.clk(clk), .clr(clr), .bus(bus));
    int checks = 0;
    int errors = 0;
    logic [63:0] exp_res = '0;
    logic [63:0] hold_res = '0;
    logic exp_dz = 1'b0;
    logic hold_dz = 1'b0;
    bit track = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // returns {div_by_zero, result}
    function automatic logic [64:0] model(input op_t o, input logic [31:0] x, input logic [31:0] y);
        int sx = x;
        int sy = y;
        if (o == OP_MUL) return {1'b0, 64'(longint'(sx) * longint'(sy))};
        if (o == OP_MULU) return {1'b0, {32'b0, x} * {32'b0, y}};
        if (y == 0) return {1'b1, x, 32'hFFFFFFFF};
        if (o == OP_DIVU) return {1'b0, x % y, x / y};
        if (x == 32'h80000000 && sy == -1) return {1'b0, 32'h0, 32'h80000000};
        return {1'b0, 32'(sx % sy), 32'(sx / sy)};
    endfunction

    always @(negedge clk) begin
        if (track) begin
            if (bus.done) begin
                chk("done_result", bus.result, exp_res);
                chk("done_dz", 64'(bus.div_by_zero), 64'(exp_dz));
                hold_res = exp_res;
                hold_dz = exp_dz;
            end else if (!bus.busy) begin
                chk("idle_result", bus.result, hold_res);
                chk("idle_dz", 64'(bus.div_by_zero), 64'(hold_dz));
            end
        end
    end

    task automatic go(input op_t o, input logic [31:0] x, input logic [31:0] y);
        logic [64:0] m;
        m = model(o, x, y);
        exp_res = m[63:0];
        exp_dz = m[64];
        bus.op = o;
        bus.X = x;
        bus.Y = y;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic wait_done(output int n);
        n = 1;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run(input op_t o, input logic [31:0] x, input logic [31:0] y, input int lat);
        int n;
        go(o, x, y);
        wait_done(n);
        chk("latency", 64'(n), 64'(lat));
        @(negedge clk);
        chk("done_one_cycle", 64'(bus.done), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [64:0] m;
        int n;
        int dones;
        bus.start = 1'b0;
        bus.op = OP_MUL;
        bus.X = '0;
        bus.Y = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_dz", 64'(bus.div_by_zero), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        clr = 1'b0;
        track = 1'b1;
        @(negedge clk);
        m = model(OP_MUL, 32'd15, -32'sd5);
        chk("model_mul", m[63:0], 64'hFFFFFFFF_FFFFFFB5);
        m = model(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        chk("model_mulu", m[63:0], 64'hFFFFFFFE_00000001);
        m = model(OP_DIV, -32'sd17, 32'd5);
        chk("model_div", m[63:0], 64'hFFFFFFFE_FFFFFFFD);
        m = model(OP_DIV, 32'h80000000, 32'hFFFFFFFF);
        chk("model_div_ovf", m[63:0], 64'h00000000_80000000);
        m = model(OP_DIVU, 32'd100, 32'd0);
        chk("model_divz", m, {1'b1, 64'h00000064_FFFFFFFF});
        run(OP_MUL, 32'd15, -32'sd5, 34);
        run(OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run(OP_DIV, -32'sd17, 32'd5, 34);
        run(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 34);
        run(OP_DIVU, 32'd100, 32'd0, 2);
        chk("divz_held", 64'(bus.div_by_zero), 64'd1);
        run(OP_DIV, 32'd17, -32'sd5, 34);
        run(OP_DIV, -32'sd7, 32'd0, 2);
        run(OP_MUL, 32'h80000000, 32'h80000000, 34);
        run(OP_DIVU, 32'hFFFFFFFF, 32'd1, 34);
        run(OP_DIVU, 32'd100, 32'd7, 34);
        run(OP_MULU, 32'h80000000, 32'd2, 34);
        go(OP_MUL, 32'd3, 32'd5);
        repeat (8) @(negedge clk);
        bus.X = 32'd7;
        bus.Y = 32'd9;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        chk("ignored_start_result", bus.result, 64'd15);
        bus.start = 1'b1;
        @(negedge clk);
        chk("start_on_done_ignored", 64'(bus.busy), 64'd0);
        bus.start = 1'b0;
        @(negedge clk);
        chk("still_idle", 64'(bus.busy), 64'd0);
        go(OP_MUL, 32'd3, 32'd5);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        track = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        hold_res = '0;
        hold_dz = 1'b0;
        track = 1'b1;
        chk("clr_busy", 64'(bus.busy), 64'd0);
        chk("clr_result", bus.result, 64'd0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        chk("no_done_after_clr", 64'(dones), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
